// File: rtl/exc_ctrl_pkg.sv
// Shared exception-control definitions (state encoding, handler vector),
// also imported by the fetch stage.
package exc_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_FLUSH  = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_HALTED = 2'd3
    } exc_state_t;

    localparam logic [15:0] SIIC_VEC = 16'h0002;

endpackage

// File: rtl/reg16_en.sv
// 16-bit register with load enable and asynchronous active-high reset.
module reg16_en (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [15:0] d,
    output logic [15:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            q <= 16'h0000;
        else if (en)
            q <= d;
    end

endmodule

// File: rtl/exc_ctrl.sv
// Exception/halt controller: accepts siic/rti/halt/err from decode, issues a
// one-cycle flush+redirect, or drains the pipe and stops for good.
module exc_ctrl
    import exc_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        id_valid,
    input  logic        stall,
    input  logic [15:0] id_pc2,
    input  logic        halt,
    input  logic        siic,
    input  logic        rti,
    input  logic        err,
    input  logic        pipe_empty,
    output logic        halt_back,
    output logic        flush,
    output logic        redirect,
    output logic [15:0] redirect_pc,
    output logic [15:0] epc,
    output logic        halted,
    output logic        exc_err
);

    exc_state_t  state, state_nx;
    logic        accept;
    logic        epc_en;
    logic        flush_q, flush_nx;
    logic [15:0] rpc_q, rpc_nx;
    logic        hb_q, hb_nx;
    logic        halted_q, halted_nx;
    logic        err_q, err_nx;

    reg16_en u_epc (
        .clk (clk),
        .rst (rst),
        .en  (epc_en),
        .d   (id_pc2),
        .q   (epc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_RUN;
            flush_q  <= 1'b0;
            rpc_q    <= 16'h0000;
            hb_q     <= 1'b0;
            halted_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state    <= state_nx;
            flush_q  <= flush_nx;
            rpc_q    <= rpc_nx;
            hb_q     <= hb_nx;
            halted_q <= halted_nx;
            err_q    <= err_nx;
        end
    end

    // Only RUN accepts events; the instruction seen during FLUSH is squashed.
    assign accept = (state == ST_RUN) && id_valid && !stall;

    always_comb begin
        state_nx  = state;
        flush_nx  = 1'b0;
        rpc_nx    = rpc_q;
        hb_nx     = hb_q;
        halted_nx = halted_q;
        err_nx    = err_q;
        epc_en    = 1'b0;
        case (state)
            ST_RUN: begin
                if (accept) begin
                    if (err) begin
                        err_nx   = 1'b1;
                        hb_nx    = 1'b1;
                        state_nx = ST_DRAIN;
                    end else if (halt) begin
                        hb_nx    = 1'b1;
                        state_nx = ST_DRAIN;
                    end else if (siic) begin
                        epc_en   = 1'b1;
                        rpc_nx   = SIIC_VEC;
                        flush_nx = 1'b1;
                        state_nx = ST_FLUSH;
                    end else if (rti) begin
                        rpc_nx   = epc;
                        flush_nx = 1'b1;
                        state_nx = ST_FLUSH;
                    end
                end
            end
            ST_FLUSH: state_nx = ST_RUN;
            ST_DRAIN: begin
                if (pipe_empty) begin
                    state_nx  = ST_HALTED;
                    halted_nx = 1'b1;
                end
            end
            ST_HALTED: state_nx = ST_HALTED;
            default:   state_nx = ST_RUN;
        endcase
    end

    // flush and redirect share one flop: they are always asserted together.
    assign flush       = flush_q;
    assign redirect    = flush_q;
    assign redirect_pc = rpc_q;
    assign halt_back   = hb_q;
    assign halted      = halted_q;
    assign exc_err     = err_q;

endmodule

// File: tb/tb_exc_ctrl.sv
// Self-checking bench for exc_ctrl: directed scenarios plus randomized
// traffic compared cycle by cycle against a behavioural model.
module tb_exc_ctrl;
    import exc_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst, id_valid, stall, halt, siic, rti, err, pipe_empty;
    logic [15:0] id_pc2;
    logic        halt_back, flush, redirect, halted, exc_err;
    logic [15:0] redirect_pc, epc;

    int n_tests = 0;
    int n_fail  = 0;

    // behavioural model
    bit          m_fl, m_hb, m_halted, m_err;
    logic [15:0] m_epc, m_rpc;

    exc_ctrl dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .stall(stall),
        .id_pc2(id_pc2), .halt(halt), .siic(siic), .rti(rti), .err(err),
        .pipe_empty(pipe_empty), .halt_back(halt_back), .flush(flush),
        .redirect(redirect), .redirect_pc(redirect_pc), .epc(epc),
        .halted(halted), .exc_err(exc_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".flush"},       16'(flush),       16'(m_fl));
        chk({tag, ".redirect"},    16'(redirect),    16'(m_fl));
        chk({tag, ".redirect_pc"}, redirect_pc,      m_rpc);
        chk({tag, ".epc"},         epc,              m_epc);
        chk({tag, ".halt_back"},   16'(halt_back),   16'(m_hb));
        chk({tag, ".halted"},      16'(halted),      16'(m_halted));
        chk({tag, ".exc_err"},     16'(exc_err),     16'(m_err));
    endtask

    task automatic model_reset();
        m_fl = 0; m_hb = 0; m_halted = 0; m_err = 0;
        m_epc = 16'h0000; m_rpc = 16'h0000;
    endtask

    // One clock of the rules: the processor is "running" when not in the
    // flush cycle and not stopping; a stopping processor halts once empty.
    task automatic model_clock();
        bit was_fl, was_hb, acc;
        was_fl = m_fl;
        was_hb = m_hb;
        acc    = !was_fl && !was_hb && id_valid && !stall;
        m_fl   = 0;
        if (was_hb && !m_halted && pipe_empty) m_halted = 1;
        if (acc) begin
            if (err) begin
                m_err = 1; m_hb = 1;
            end else if (halt) begin
                m_hb = 1;
            end else if (siic) begin
                m_epc = id_pc2; m_rpc = SIIC_VEC; m_fl = 1;
            end else if (rti) begin
                m_rpc = m_epc; m_fl = 1;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_clock();
        #1;
        check_all("cyc");
    endtask

    task automatic drive(input bit v, input bit st, input bit h, input bit s,
                         input bit r, input bit e, input bit pe, input logic [15:0] pc);
        id_valid = v; stall = st; halt = h; siic = s; rti = r; err = e;
        pipe_empty = pe; id_pc2 = pc;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 16'h0000);
    endtask

    // Reset pulse placed mid-cycle, away from any clock edge.
    task automatic async_rst();
        #2 rst = 1'b1;
        model_reset();
        #1 check_all("arst");
        #3 rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        model_reset();
        #12 check_all("reset");
        rst = 1'b0;
        step();

        // siic then flush cycle
        drive(1, 0, 0, 1, 0, 0, 0, 16'h0104);
        step();
        chk("siic.flush", 16'(flush), 16'h1);
        chk("siic.rpc", redirect_pc, 16'h0002);
        chk("siic.epc", epc, 16'h0104);
        idle();
        step();
        chk("siic.flush_off", 16'(flush), 16'h0);

        // rti returns to saved epc
        drive(1, 0, 0, 0, 1, 0, 0, 16'h0400);
        step();
        chk("rti.redirect", 16'(redirect), 16'h1);
        chk("rti.rpc", redirect_pc, 16'h0104);
        idle();
        step();
        chk("rti.redirect_off", 16'(redirect), 16'h0);

        // event during flush cycle is squashed
        drive(1, 0, 0, 1, 0, 0, 0, 16'h0200);
        step();
        drive(1, 0, 0, 1, 0, 0, 0, 16'h0300);
        step();
        chk("squash.flush", 16'(flush), 16'h0);
        chk("squash.epc", epc, 16'h0200);

        // stalled siic is ignored, then accepted
        drive(1, 1, 0, 1, 0, 0, 0, 16'h0400);
        step();
        chk("stall.flush", 16'(flush), 16'h0);
        chk("stall.epc", epc, 16'h0200);
        stall = 1'b0;
        step();
        chk("unstall.flush", 16'(flush), 16'h1);
        chk("unstall.epc", epc, 16'h0400);
        idle();
        step();

        // err wins over siic
        drive(1, 0, 0, 1, 0, 1, 0, 16'h0500);
        step();
        chk("err.exc_err", 16'(exc_err), 16'h1);
        chk("err.halt_back", 16'(halt_back), 16'h1);
        chk("err.redirect", 16'(redirect), 16'h0);
        chk("err.epc", epc, 16'h0400);
        idle();
        step();

        // async reset while draining, then normal siic
        async_rst();
        chk("drst.halt_back", 16'(halt_back), 16'h0);
        chk("drst.exc_err", 16'(exc_err), 16'h0);
        chk("drst.epc", epc, 16'h0000);
        drive(1, 0, 0, 1, 0, 0, 0, 16'h0600);
        step();
        chk("drst.siic_flush", 16'(flush), 16'h1);
        chk("drst.siic_epc", epc, 16'h0600);
        idle();
        step();

        // rti after reset with no siic goes to 0
        async_rst();
        drive(1, 0, 0, 0, 1, 0, 0, 16'h0700);
        step();
        chk("rti0.rpc", redirect_pc, 16'h0000);
        idle();
        step();

        // halt with pipe draining for 3 cycles
        drive(1, 0, 1, 0, 0, 0, 0, 16'h0800);
        step();
        chk("halt.halt_back", 16'(halt_back), 16'h1);
        chk("halt.halted0", 16'(halted), 16'h0);
        idle();
        step();
        step();
        chk("halt.halted1", 16'(halted), 16'h0);
        pipe_empty = 1'b1;
        step();
        chk("halt.halted2", 16'(halted), 16'h1);
        for (int i = 0; i < 12; i++) begin
            drive(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                  1'($urandom), 1'($urandom), 1'($urandom), 16'($urandom));
            step();
            chk("halt.sticky_hb", 16'(halt_back), 16'h1);
            chk("halt.sticky_h", 16'(halted), 16'h1);
        end
        idle();
        async_rst();

        // randomized traffic with occasional mid-cycle resets
        for (int i = 0; i < 800; i++) begin
            drive($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 2,
                  $urandom_range(0, 19) == 0, $urandom_range(0, 9) < 2,
                  $urandom_range(0, 9) < 2, $urandom_range(0, 29) == 0,
                  $urandom_range(0, 9) < 3, 16'($urandom));
            if ($urandom_range(0, 39) == 0)
                async_rst();
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
